// File: rtl/cmp_dmem_arbiter_if.sv
// rtl/cmp_dmem_arbiter_if.sv - node-side and dmem-side signal bundle for the dmem arbiter
interface cmp_dmem_arbiter_if;
  logic [0:3]   req;
  logic [0:3]   wr;
  logic [0:3]   lock;
  logic [0:31]  addr;
  logic [0:255] wdata;
  logic [0:3]   gnt;
  logic [0:3]   rvalid;
  logic [0:63]  rdata;
  logic         mem_en;
  logic         mem_wr_en;
  logic [0:7]   mem_addr;
  logic [0:63]  mem_din;
  logic [0:63]  mem_dout;

  // Nodes plus the dmem instance: drives requests and memory read data.
  modport master (
    output req, wr, lock, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_din
  );

  // Arbiter view.
  modport slave (
    input  req, wr, lock, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, mem_en, mem_wr_en, mem_addr, mem_din
  );
endinterface

// File: rtl/cmp_dmem_arbiter.sv
// rtl/cmp_dmem_arbiter.sv - round-robin arbiter with bounded lock sharing one 256x64 dmem
module cmp_dmem_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  cmp_dmem_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic [1:0] owner, owner_nxt;
  logic [3:0] lock_cnt, lock_cnt_nxt;
  logic [0:3] gnt;
  logic [0:3] rvalid_q;
  logic [1:0] sel;
  logic       granted;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;

  // Round-robin scan: first requester after last_grant, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant decision and next state; everything is held quiet while reset is high.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    lock_cnt_nxt   = lock_cnt;
    gnt            = 4'b0000;
    sel            = 2'd0;
    granted        = 1'b0;
    if (!reset) begin
      case (state)
        ARB: begin
          if (found) begin
            gnt[win]       = 1'b1;
            sel            = win;
            granted        = 1'b1;
            last_grant_nxt = win;
            if (bus.lock[win] && (MAX_LOCK > 1)) begin
              state_nxt    = LOCKED;
              owner_nxt    = win;
              lock_cnt_nxt = 4'd1;
            end
          end
        end
        LOCKED: begin
          // last_grant is left at owner so the others go first on exit.
          if (bus.req[owner]) begin
            gnt[owner]   = 1'b1;
            sel          = owner;
            granted      = 1'b1;
            lock_cnt_nxt = lock_cnt + 4'd1;
            if (!bus.lock[owner] || (lock_cnt + 4'd1 == MAX_LOCK_C)) begin
              state_nxt = ARB;
            end
          end else begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // Route the granted node's fields to the dmem port.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_din   = 64'h0;
    if (granted) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr_en = bus.wr[sel];
      bus.mem_addr  = bus.addr[{sel, 3'b000} +: 8];
      bus.mem_din   = bus.wdata[{sel, 6'b000000} +: 64];
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= 2'd3;
      owner      <= 2'd0;
      lock_cnt   <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  // Read-return flag: valid in the cycle after a read grant, dmem data passes through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 4'b0000;
    end else begin
      rvalid_q <= gnt & ~bus.wr;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = bus.mem_dout;

endmodule

// File: tb/tb_cmp_dmem_arbiter.sv
// tb/tb_cmp_dmem_arbiter.sv - scoreboard bench for the round-robin dmem arbiter
module tb_cmp_dmem_arbiter;

  logic clk;
  logic reset;

  cmp_dmem_arbiter_if bus();

  cmp_dmem_arbiter #(.MAX_LOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        wr;
    logic        lock;
    logic [7:0]  addr;
    logic [63:0] data;
  } op_t;

  typedef struct {
    int          node;
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] data;
  } exp_gnt_t;

  typedef struct {
    int          node;
    logic [63:0] data;
  } exp_rd_t;

  op_t      ops [0:3][0:7];
  int       nops [0:3];
  int       pos  [0:3];
  exp_gnt_t exp_g[$];
  exp_rd_t  exp_r[$];
  int       vectors = 0;
  int       miscompares = 0;

  logic [0:63] dm [0:255];

  // dmem model: synchronous write and registered read
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr_en) dm[bus.mem_addr] = bus.mem_din;
      else               bus.mem_dout = dm[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_gnt_t    m_g;
  exp_rd_t     m_r;
  logic [0:3]  m_v;

  // scoreboard monitor: compare every grant and every read return against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.gnt != 4'b0000) begin
        if (exp_g.size() == 0) begin
          check("unexpected_gnt", 256'(bus.gnt), 256'(0));
        end else begin
          m_g = exp_g.pop_front();
          m_v = 4'b0000;
          m_v[m_g.node] = 1'b1;
          check("gnt", 256'(bus.gnt), 256'(m_v));
          check("mem_en", 256'(bus.mem_en), 256'(1));
          check("mem_wr_en", 256'(bus.mem_wr_en), 256'(m_g.wr));
          check("mem_addr", 256'(bus.mem_addr), 256'(m_g.addr));
          if (m_g.wr) check("mem_din", 256'(bus.mem_din), 256'(m_g.data));
        end
      end
      if (bus.rvalid != 4'b0000) begin
        if (exp_r.size() == 0) begin
          check("unexpected_rvalid", 256'(bus.rvalid), 256'(0));
        end else begin
          m_r = exp_r.pop_front();
          m_v = 4'b0000;
          m_v[m_r.node] = 1'b1;
          check("rvalid", 256'(bus.rvalid), 256'(m_v));
          check("rdata", 256'(bus.rdata), 256'(m_r.data));
        end
      end
    end
  end

  task automatic op(input int k, input logic w, input logic l, input logic [7:0] a, input logic [63:0] d);
    ops[k][nops[k]] = '{wr: w, lock: l, addr: a, data: d};
    nops[k]++;
  endtask

  task automatic eg(input int k, input logic w, input logic [7:0] a, input logic [63:0] d);
    exp_g.push_back('{node: k, wr: w, addr: a, data: d});
  endtask

  task automatic er(input int k, input logic [63:0] d);
    exp_r.push_back('{node: k, data: d});
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < 4; k++) begin
      if (pos[k] < nops[k]) begin
        bus.req[k]             = 1'b1;
        bus.wr[k]              = ops[k][pos[k]].wr;
        bus.lock[k]            = ops[k][pos[k]].lock;
        bus.addr[8*k +: 8]     = ops[k][pos[k]].addr;
        bus.wdata[64*k +: 64]  = ops[k][pos[k]].data;
      end else begin
        bus.req[k]  = 1'b0;
        bus.wr[k]   = 1'b0;
        bus.lock[k] = 1'b0;
      end
    end
  endtask

  function automatic logic all_done();
    logic d = 1'b1;
    for (int k = 0; k < 4; k++) if (pos[k] < nops[k]) d = 1'b0;
    return d;
  endfunction

  // present each node's next op, advancing it only once the node has been granted
  task automatic run(input string name, input int budget);
    int cyc = 0;
    logic [0:3] g;
    while (!all_done() && cyc < budget) begin
      apply_inputs();
      @(negedge clk);
      g = bus.gnt;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (g[k]) pos[k]++;
      cyc++;
    end
    check({name, "_ops_consumed"}, 256'(all_done()), 256'(1));
    for (int k = 0; k < 4; k++) pos[k] = nops[k];
    apply_inputs();
  endtask

  task automatic idle(input int n);
    apply_inputs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) begin
      nops[k] = 0;
      pos[k]  = 0;
    end
    apply_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 64'h0;
    dm[8'h05] = 64'h1122334455667788;
    for (int k = 0; k < 4; k++) begin
      nops[k] = 0;
      pos[k]  = 0;
    end
    bus.addr  = '0;
    bus.wdata = '0;
    reset = 1'b1;

    // reset: node 2 requesting, outputs must stay quiet
    op(2, 1'b0, 1'b0, 8'h05, 64'h0);
    apply_inputs();
    @(negedge clk);
    check("rst_gnt", 256'(bus.gnt), 256'(0));
    check("rst_mem_en", 256'(bus.mem_en), 256'(0));
    check("rst_mem_wr_en", 256'(bus.mem_wr_en), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
    check("rst_mem_din", 256'(bus.mem_din), 256'(0));
    check("rst_rvalid", 256'(bus.rvalid), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    eg(2, 1'b0, 8'h05, 64'h0);
    er(2, 64'h1122334455667788);
    run("t1", 20);
    idle(2);

    // all four nodes write continuously: strict rotation 0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        op(k, 1'b1, 1'b0, 8'(8'h10 + k), 64'(k));
        eg(k, 1'b1, 8'(8'h10 + k), 64'(k));
      end
    run("t2", 30);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      op(0, 1'b0, 1'b0, 8'(8'h10 + i), 64'h0);
      eg(0, 1'b0, 8'(8'h10 + i), 64'h0);
      er(0, 64'(i));
    end
    run("t2_readback", 20);
    idle(2);

    // node 1 locks for 6 reads against node 3: 1,1,1,1,3,1,1
    do_reset();
    for (int i = 0; i < 6; i++) op(1, 1'b0, 1'b1, 8'(8'h10 + (i % 4)), 64'h0);
    op(3, 1'b0, 1'b0, 8'h05, 64'h0);
    for (int i = 0; i < 4; i++) begin
      eg(1, 1'b0, 8'(8'h10 + i), 64'h0);
      er(1, 64'(i));
    end
    eg(3, 1'b0, 8'h05, 64'h0);
    er(3, 64'h1122334455667788);
    for (int i = 0; i < 2; i++) begin
      eg(1, 1'b0, 8'(8'h10 + i), 64'h0);
      er(1, 64'(i));
    end
    run("t3", 40);
    idle(2);

    // node 0 lock then release: 0,0,1,0
    do_reset();
    op(0, 1'b0, 1'b1, 8'h10, 64'h0);
    op(0, 1'b0, 1'b0, 8'h11, 64'h0);
    op(0, 1'b0, 1'b0, 8'h12, 64'h0);
    op(1, 1'b0, 1'b0, 8'h13, 64'h0);
    eg(0, 1'b0, 8'h10, 64'h0); er(0, 64'd0);
    eg(0, 1'b0, 8'h11, 64'h0); er(0, 64'd1);
    eg(1, 1'b0, 8'h13, 64'h0); er(1, 64'd3);
    eg(0, 1'b0, 8'h12, 64'h0); er(0, 64'd2);
    run("t4", 30);
    idle(2);

    // write by node 0 then read of the same word by node 1 in the next cycle
    do_reset();
    op(0, 1'b1, 1'b0, 8'h20, 64'hA);
    op(1, 1'b0, 1'b0, 8'h20, 64'h0);
    eg(0, 1'b1, 8'h20, 64'hA);
    eg(1, 1'b0, 8'h20, 64'h0);
    er(1, 64'hA);
    run("t5", 20);
    idle(2);

    // lock held across writes keeps node 1 waiting
    do_reset();
    op(0, 1'b1, 1'b1, 8'h30, 64'h5);
    op(0, 1'b1, 1'b0, 8'h31, 64'h6);
    op(1, 1'b0, 1'b0, 8'h30, 64'h0);
    eg(0, 1'b1, 8'h30, 64'h5);
    eg(0, 1'b1, 8'h31, 64'h6);
    eg(1, 1'b0, 8'h30, 64'h0);
    er(1, 64'h5);
    run("t5b", 20);
    idle(2);

    // reset right after a locking node-3 read grant drops the return and the lock
    do_reset();
    op(3, 1'b0, 1'b1, 8'h05, 64'h0);
    eg(3, 1'b0, 8'h05, 64'h0);
    run("t6", 20);
    reset = 1'b1;
    op(0, 1'b0, 1'b0, 8'h10, 64'h0);
    op(3, 1'b0, 1'b0, 8'h11, 64'h0);
    apply_inputs();
    @(negedge clk);
    check("t6_rst_rvalid", 256'(bus.rvalid), 256'(0));
    check("t6_rst_gnt", 256'(bus.gnt), 256'(0));
    check("t6_rst_mem_en", 256'(bus.mem_en), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    eg(0, 1'b0, 8'h10, 64'h0); er(0, 64'd0);
    eg(3, 1'b0, 8'h11, 64'h0); er(3, 64'd1);
    run("t6_after", 20);
    idle(3);

    check("exp_gnt_left", 256'(exp_g.size()), 256'(0));
    check("exp_rd_left", 256'(exp_r.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_dmem_arbiter.md
Name: cmp_dmem_arbiter

Overview:
Round-robin arbiter that shares one 256x64 data memory (dmem: memEn, memWrEn, 8-bit memAddr, 64-bit dataIn/dataOut, synchronous read) among the four cardinal_cmp nodes. It sits between the node load/store ports and the shared dmem instance. It supports a bounded lock mode so one node can issue back-to-back accesses (block copy or read-modify-write) without interleaving from other nodes. Bit numbering is big-endian throughout ([0:N-1], bit 0 = MSB); node k's fields are slice k of each packed bus.

Parameters:
MAX_LOCK, 4, maximum consecutive grants a locking node may hold per tenure (1 = lock ignored; legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
req  input  [0:3]  node k requests an access this cycle; must hold req/wr/addr/wdata stable until gnt[k]
wr  input  [0:3]  1 = write, 0 = read
lock  input  [0:3]  request to keep ownership after this grant
addr  input  [0:31]  node k address at [8k:8k+7]
wdata  input  [0:255]  node k write data at [64k:64k+63]
gnt  output  [0:3]  one-hot (or zero) combinational grant; the access is performed at the next posedge
rvalid  output  [0:3]  registered; rvalid[k]=1 the cycle after a read grant to node k
rdata  output  [0:63]  read data, equal to mem_dout; meaningful only while a bit of rvalid is set
mem_en  output  1  to dmem memEn
mem_wr_en  output  1  to dmem memWrEn
mem_addr  output  [0:7]  to dmem memAddr
mem_din  output  [0:63]  to dmem dataIn
mem_dout  input  [0:63]  from dmem dataOut

Behaviour:
- State: fsm {ARB, LOCKED}, last_grant[1:0], owner[1:0], lock_cnt[3:0], rvalid register.
- Reset (async): fsm=ARB, last_grant=3 (node 0 has first priority), owner=0, lock_cnt=0, rvalid=0. While reset is high: gnt=0, mem_en=0, mem_wr_en=0, mem_addr=0, mem_din=0.
- ARB: the winner is the first k with req[k]=1, scanning from (last_grant+1) mod 4 upward with wrap. gnt[winner]=1; on the posedge, last_grant<=winner.
  - If lock[winner]=1 and MAX_LOCK>1: go to LOCKED, owner<=winner, lock_cnt<=1.
- LOCKED: only owner can be granted; all other gnt bits are 0.
  - If req[owner]=1: gnt[owner]=1 and lock_cnt increments.
  - Return to ARB after this grant if lock[owner]=0 or lock_cnt+1==MAX_LOCK.
  - If req[owner]=0: no grant, mem_en=0 (idle cycle); go to ARB next cycle.
  - last_grant stays = owner, so other nodes get priority on exit.
- Memory mux (combinational): when any gnt is set, mem_en=1, mem_wr_en=wr[g], mem_addr=addr slice g, mem_din=wdata slice g. With no grant, all are 0.
- Write latency: the write is committed at the posedge ending the grant cycle. A read granted in the next cycle to any node returns the new data; no forwarding is needed.
- Read latency: 1. rvalid[g]<=gnt[g]&~wr[g] at the posedge, and rvalid clears the following cycle unless the node is re-granted for a read. rdata=mem_dout (pass-through). Back-to-back reads give one result per cycle.
- At most one rvalid bit is set at any time. A write grant sets no rvalid bit.
- Maximum throughput: one access per cycle. No node waits more than 3 grants in ARB, plus 3*MAX_LOCK cycles in total when all other nodes lock.
- Reset mid-operation: a pending read return is dropped (rvalid=0) and a lock tenure is abandoned.
- A lock asserted on a write grant behaves the same as on a read grant.

Test Plan:
- Reset, DM[0x05]=64'h1122334455667788. Node 2 reads 0x05 → gnt=4'b0010 in the same cycle, next cycle rvalid=4'b0010 and rdata=64'h1122334455667788; all mem_* outputs are 0 during reset.
- All four nodes hold write requests continuously (addr 0x10+k, data k) → gnt sequence 0,1,2,3,0,… one per cycle; DM[0x10..0x13]=0,1,2,3; rvalid stays 0.
- MAX_LOCK=4: node 1 requests with lock=1 for 6 reads while node 3 requests → node 1 granted 4 consecutive cycles, then node 3 granted, then node 1 resumes.
- Node 0 asserts lock on its first grant and drops lock on its second → exactly 2 node-0 grants, then node 1 (which was pending) is granted.
- Node 0 writes 64'hA at 0x20 in cycle t; node 1 reads 0x20 granted in cycle t+1 → rvalid[1] at t+2 with rdata=64'hA.
- Assert reset in the cycle after a node-3 read grant → rvalid stays 0, fsm=ARB; after release, node 0 wins the first contention with node 3.
